// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with clock enable and a counted
// burst mode. A single start request in IDLE runs `count` shifts
// autonomously, reporting progress through busy and a one-cycle done pulse.
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             cp,
    input  logic             mr_,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] p,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_SHLS  = 3'b110;
    localparam logic [2:0] M_CLR   = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    // Next register value for one operation; "right" moves bits toward the MSB
    // with dsr entering q[0], "left" moves toward the LSB with dsl entering the MSB.
    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sr,
        input logic             sl,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] nxt;
        case (op)
            M_HOLD: nxt = cur;
            M_SHR:  nxt = {cur[WIDTH-2:0], sr};
            M_SHL:  nxt = {sl, cur[WIDTH-1:1]};
            M_LOAD: nxt = ld;
            M_ROR:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROL:  nxt = {cur[0], cur[WIDTH-1:1]};
            M_SHLS: nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:  nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Only the shift and rotate operations can be repeated by a burst.
    function automatic logic is_burstable(input logic [2:0] op);
        return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
               (op == M_ROL) || (op == M_SHLS);
    endfunction

    // State register; synchronous active-low reset wins over everything.
    always_ff @(posedge cp) begin
        if (!mr_) begin
            state_q <= IDLE;
            q_q     <= '0;
            op_q    <= M_HOLD;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic: immediate operations in IDLE, latched op while RUN.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        op_d    = op_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (ce) begin
                    if (start && is_burstable(mode)) begin
                        // q is untouched on the accepting edge; shifting starts in RUN.
                        if (count != '0) begin
                            op_d    = mode;
                            rem_d   = count;
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        q_d = apply_op(mode, q_q, dsr, dsl, p);
                    end
                end
            end
            RUN: begin
                if (ce) begin
                    q_d   = apply_op(op_q, q_q, dsr, dsl, p);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Leaves after one cycle regardless of ce so done is a clean pulse.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q    = q_q;
    assign so_r = q_q[WIDTH-1];
    assign so_l = q_q[0];
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
